wb_port_arbiter: RTL

Shares the register file's single write port between NREQ write-back requesters (e.g. main pipeline, multi-cycle divider, load return) using round-robin arbitration over a valid/ready handshake. Drives the regfile `we`/`waddr`/`wdata` from a registered output stage, so at most one register write is issued per cycle. Optionally tracks destination registers with outstanding long-latency writes (busy scoreboard) so decode can stall on RAW hazards.

---
 rtl/wb_port_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ write-back requesters.
// Optional busy scoreboard for RAW stalls is compiled in when WB_SCOREBOARD_EN is defined.
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  output logic [GW-1:0]        grant_id,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  output logic [(2**AW)-1:0]   busy
);

  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt;
  logic            found;
  logic [GW:0]     cand;
  logic [NREQ-1:0] gnt_oh;
  logic            xfer;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  logic            we_q;
  logic [AW-1:0]   waddr_q;
  logic [DW-1:0]   wdata_q;
  logic [GW-1:0]   grant_q;

  // Search ptr, ptr+1, ... mod NREQ for the first valid requester.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
      if (!found && req_valid[cand[GW-1:0]]) begin
        found = 1'b1;
        gnt   = cand[GW-1:0];
      end
    end
  end

  assign gnt_oh    = found ? (NREQ'(1) << gnt) : '0;
  assign req_ready = rst ? '0 : gnt_oh;
  assign xfer      = |req_ready;
  assign gnt_addr  = req_addr[gnt*AW +: AW];
  assign gnt_data  = req_data[gnt*DW +: DW];
  assign ptr_d     = (gnt == GW'(NREQ-1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (xfer) begin
      we_q    <= (gnt_addr != '0);
      waddr_q <= gnt_addr;
      wdata_q <= gnt_data;
      grant_q <= gnt;
      ptr_q   <= ptr_d;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign grant_id = grant_q;

`ifdef WB_SCOREBOARD_EN
  logic [(2**AW)-1:0] busy_q, busy_d, set_m, clr_m;

  // Set beats clear on the same edge: a newer producer has claimed the register.
  always_comb begin
    set_m  = '0;
    clr_m  = '0;
    if (claim_valid && claim_addr != '0) set_m[claim_addr] = 1'b1;
    if (we_q) clr_m[waddr_q] = 1'b1;
    busy_d    = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_claim;
  assign unused_claim = ^{claim_valid, claim_addr};
  assign busy = '0;
`endif

endmodule
